mem_arbiter: RTL and testbench

//  Shares one port of the system dual-port memory between two requesters.
//  The requesters are the video fetch unit and the CPU core bus.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one memory port: video has fixed priority, the CPU
// is guaranteed a grant after P_cpu_max_wait consecutive lost arbitrations.
module mem_arbiter #(
  parameter int P_addr_bits    = 16,
  parameter int P_data_bits    = 8,
  parameter int P_cpu_max_wait = 2
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic                   I_vid_req,
  input  logic [P_addr_bits-1:0] I_vid_addr,
  output logic                   O_vid_ack,
  output logic                   O_vid_valid,
  output logic [P_data_bits-1:0] O_vid_data,
  input  logic                   I_cpu_req,
  input  logic                   I_cpu_rdwr,
  input  logic [P_addr_bits-1:0] I_cpu_addr,
  input  logic [P_data_bits-1:0] I_cpu_wr_data,
  output logic                   O_cpu_ack,
  output logic                   O_cpu_valid,
  output logic [P_data_bits-1:0] O_cpu_data,
  output logic [P_addr_bits-1:0] O_mem_addr,
  output logic                   O_mem_rden,
  output logic                   O_mem_wren,
  output logic [P_data_bits-1:0] O_mem_data,
  input  logic [P_data_bits-1:0] I_mem_data
);

  localparam int WW = $clog2(P_cpu_max_wait + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(P_cpu_max_wait);

  // Handshake: a requester raises req with its address/command and holds them
  // unchanged until it sees a one-cycle ack; the request is accepted in the
  // ack cycle. A requester whose ack is high in a cycle is not eligible in that
  // cycle, because it only reacts to the ack on the following edge.

  logic          vid_elig, cpu_elig, cpu_forced;
  logic          vid_win, cpu_win;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]    tag_g, tag_s;  // {vid, cpu} read tags in grant cycle and the one after

  always_comb begin
    vid_elig     = I_vid_req & ~O_vid_ack;
    cpu_elig     = I_cpu_req & ~O_cpu_ack;
    cpu_forced   = (wait_cnt == WAIT_MAX);
    cpu_win      = cpu_elig & (~vid_elig | cpu_forced);
    vid_win      = vid_elig & ~cpu_win;
    wait_cnt_nxt = wait_cnt;
    if (cpu_win) begin
      wait_cnt_nxt = '0;
    end else if (cpu_elig && !cpu_forced) begin
      wait_cnt_nxt = wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      O_vid_ack   <= 1'b0;
      O_cpu_ack   <= 1'b0;
      O_mem_rden  <= 1'b0;
      O_mem_wren  <= 1'b0;
      O_mem_addr  <= '0;
      O_mem_data  <= '0;
      O_vid_valid <= 1'b0;
      O_cpu_valid <= 1'b0;
      O_vid_data  <= '0;
      O_cpu_data  <= '0;
      tag_g       <= 2'b00;
      tag_s       <= 2'b00;
      wait_cnt    <= '0;
    end else begin
      O_vid_ack  <= vid_win;
      O_cpu_ack  <= cpu_win;
      O_mem_rden <= vid_win | (cpu_win & I_cpu_rdwr);
      O_mem_wren <= cpu_win & ~I_cpu_rdwr;
      if (vid_win) begin
        O_mem_addr <= I_vid_addr;
      end else if (cpu_win) begin
        O_mem_addr <= I_cpu_addr;
      end
      if (cpu_win && !I_cpu_rdwr) begin
        O_mem_data <= I_cpu_wr_data;
      end
      // Memory data arrives the cycle after the strobe; it is captured then and
      // presented one cycle later to whichever requester issued the read.
      tag_g       <= {vid_win, cpu_win & I_cpu_rdwr};
      tag_s       <= tag_g;
      O_vid_valid <= tag_s[1];
      O_cpu_valid <= tag_s[0];
      if (tag_s[1]) begin
        O_vid_data <= I_mem_data;
      end
      if (tag_s[0]) begin
        O_cpu_data <= I_mem_data;
      end
      wait_cnt <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random requesters, a grant-rule reference model with
// its own memory image, and queues of expected read returns.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack, vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_req, cpu_rdwr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack, cpu_valid;
  logic [DW-1:0] cpu_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rden, mem_wren;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.P_addr_bits(AW), .P_data_bits(DW), .P_cpu_max_wait(MAXW)) dut (
    .I_clock(clk), .I_reset(rst_n),
    .I_vid_req(vid_req), .I_vid_addr(vid_addr),
    .O_vid_ack(vid_ack), .O_vid_valid(vid_valid), .O_vid_data(vid_data),
    .I_cpu_req(cpu_req), .I_cpu_rdwr(cpu_rdwr), .I_cpu_addr(cpu_addr),
    .I_cpu_wr_data(cpu_wdata),
    .O_cpu_ack(cpu_ack), .O_cpu_valid(cpu_valid), .O_cpu_data(cpu_data),
    .O_mem_addr(mem_addr), .O_mem_rden(mem_rden), .O_mem_wren(mem_wren),
    .O_mem_data(mem_wdata), .I_mem_data(mem_rdata)
  );

  // ---------------- clock / reset / memory device ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] dev_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_wren === 1'b1) dev_mem[mem_addr] <= mem_wdata;
    if (mem_rden === 1'b1) mem_rdata <= dev_mem[mem_addr];
  end

  // ---------------- counters / check helper ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: no ack within budget (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model + scoreboard ----------------
  bit            chk_en = 1'b0;
  int            vid_last, cpu_last, cpu_losses;
  bit            m_rden, m_wren;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] vid_hold, cpu_hold;
  logic [DW-1:0] exp_vid_q[$];
  logic [DW-1:0] exp_cpu_q[$];
  int            vid_due_q[$];
  int            cpu_due_q[$];
  bit            v_el, c_el, v_win, c_win;

  always @(negedge clk) begin
    if (chk_en) begin
      check("vid_ack",  32'(vid_ack),   32'(vid_last == cyc));
      check("cpu_ack",  32'(cpu_ack),   32'(cpu_last == cyc));
      check("mem_rden", 32'(mem_rden),  32'(m_rden));
      check("mem_wren", 32'(mem_wren),  32'(m_wren));
      check("mem_addr", 32'(mem_addr),  32'(m_addr));
      check("mem_data", 32'(mem_wdata), 32'(m_wdata));
      if (vid_due_q.size() > 0 && vid_due_q[0] == cyc) begin
        check("vid_valid", 32'(vid_valid), 32'd1);
        check("vid_data",  32'(vid_data),  32'(exp_vid_q[0]));
        vid_hold = exp_vid_q.pop_front();
        void'(vid_due_q.pop_front());
      end else begin
        check("vid_valid_idle", 32'(vid_valid), 32'd0);
        check("vid_data_hold",  32'(vid_data),  32'(vid_hold));
      end
      if (cpu_due_q.size() > 0 && cpu_due_q[0] == cyc) begin
        check("cpu_valid", 32'(cpu_valid), 32'd1);
        check("cpu_data",  32'(cpu_data),  32'(exp_cpu_q[0]));
        cpu_hold = exp_cpu_q.pop_front();
        void'(cpu_due_q.pop_front());
      end else begin
        check("cpu_valid_idle", 32'(cpu_valid), 32'd0);
        check("cpu_data_hold",  32'(cpu_data),  32'(cpu_hold));
      end
    end

    // Decide what the next cycle must show, from the inputs of this cycle.
    if (rst_n !== 1'b1) begin
      vid_last   = -10;
      cpu_last   = -10;
      cpu_losses = 0;
      m_rden     = 1'b0;
      m_wren     = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      vid_hold   = '0;
      cpu_hold   = '0;
      exp_vid_q.delete();
      exp_cpu_q.delete();
      vid_due_q.delete();
      cpu_due_q.delete();
      chk_en     = 1'b1;
    end else if (chk_en) begin
      v_el   = vid_req && (vid_last != cyc);
      c_el   = cpu_req && (cpu_last != cyc);
      c_win  = c_el && (!v_el || cpu_losses >= MAXW);
      v_win  = v_el && !c_win;
      m_rden = 1'b0;
      m_wren = 1'b0;
      if (v_win) begin
        vid_last = cyc + 1;
        m_rden   = 1'b1;
        m_addr   = vid_addr;
        exp_vid_q.push_back(ref_mem[vid_addr]);
        vid_due_q.push_back(cyc + 3);
      end
      if (c_win) begin
        cpu_last   = cyc + 1;
        cpu_losses = 0;
        m_addr     = cpu_addr;
        if (cpu_rdwr) begin
          m_rden = 1'b1;
          exp_cpu_q.push_back(ref_mem[cpu_addr]);
          cpu_due_q.push_back(cyc + 3);
        end else begin
          m_wren            = 1'b1;
          m_wdata           = cpu_wdata;
          ref_mem[cpu_addr] = cpu_wdata;
        end
      end else if (c_el && cpu_losses < MAXW) begin
        cpu_losses++;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_one(input logic [AW-1:0] a);
    int k = 0;
    vid_req  = 1'b1;
    vid_addr = a;
    do begin
      step();
      k++;
    end while (vid_ack !== 1'b1 && k < 64);
    if (vid_ack !== 1'b1) timeout("vid_ack_wait");
  endtask

  task automatic cpu_one(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int wd_pct);
    int k = 0;
    bit done = 1'b0;
    cpu_req   = 1'b1;
    cpu_rdwr  = rw;
    cpu_addr  = a;
    cpu_wdata = d;
    while (!done) begin
      step();
      k++;
      if (cpu_ack === 1'b1) begin
        done = 1'b1;
      end else if ($urandom_range(0, 99) < wd_pct) begin
        cpu_req = 1'b0;
        step();
        done = 1'b1;
      end else if (k >= 64) begin
        timeout("cpu_ack_wait");
        done = 1'b1;
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'(16'h0200 + $urandom_range(0, 7));
  endfunction

  task automatic vid_run(input int n, input int gap_pct, input bit fixed, input logic [AW-1:0] a);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        vid_req = 1'b0;
        step();
      end
      vid_one(fixed ? a : rand_addr());
    end
    vid_req = 1'b0;
  endtask

  task automatic cpu_run(input int n, input int gap_pct, input int wd_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        cpu_req = 1'b0;
        step();
      end
      cpu_one(1'($urandom_range(0, 1)), rand_addr(), DW'($urandom_range(0, 255)), wd_pct);
    end
    cpu_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dev_mem[i] = DW'($urandom_range(0, 255));
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[16'h6000] = 8'h41;
    ref_mem[16'h6000] = 8'h41;
    rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_rdwr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // isolated video read
    vid_run(1, 0, 1'b1, 16'h6000);
    repeat (4) step();

    // CPU write then read back
    cpu_one(1'b0, 16'h0200, 8'h5A, 0);
    cpu_req = 1'b0;
    step();
    cpu_one(1'b1, 16'h0200, 8'h00, 0);
    cpu_req = 1'b0;
    repeat (4) step();

    // both requesters held continuously
    fork
      vid_run(12, 0, 1'b0, '0);
      cpu_run(12, 0, 0);
    join
    repeat (4) step();

    // one-cycle CPU pulse against a video stream
    cpu_one(1'b1, 16'h0201, 8'h00, 0);
    cpu_req = 1'b0;
    step();
    fork
      vid_run(6, 0, 1'b0, '0);
      begin
        cpu_req = 1'b1; cpu_rdwr = 1'b0; cpu_addr = 16'h0203; cpu_wdata = 8'hC3;
        step();
        cpu_req = 1'b0;
      end
    join
    repeat (4) step();

    // reset during the cycle after a video grant
    vid_one(16'h6000);
    vid_req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // random traffic with idles and withdrawals
    fork
      vid_run(40, 40, 1'b0, '0);
      cpu_run(40, 40, 10);
    join
    fork
      vid_run(40, 10, 1'b0, '0);
      cpu_run(40, 10, 5);
    join
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
